// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-locked arbiter sharing the write port of
// the async FIFO between NUM_REQ requesters in the wr_clk domain.
//
// Ports:
//   wr_clk, rst     clock, asynchronous active-high reset
//   req_valid/last  per-requester beat valid and end-of-burst marker
//   req_data        requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready       per-requester beat accepted this cycle
//   fifo_full       FIFO backpressure
//   fifo_wr_en      FIFO write strobe
//   fifo_wdata      {grant_id, last, data}, zero when not writing
//   grant_id        currently granted requester
//   busy            high while a grant is held
//
// A grant lasts until the granted requester's last beat or MAX_BURST beats,
// then one IDLE cycle re-arbitrates starting after the released requester.

// Per-requester slice: qualifies the handshake and masks the payload so the
// top level can simply OR all lanes together.
module fifo_wr_arbiter_lane #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  gnt,
  input  logic                  valid,
  input  logic                  last,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  fifo_full,
  output logic                  xfer,
  output logic                  last_m,
  output logic [DATA_WIDTH-1:0] data_m
);
  assign xfer   = gnt & valid & ~fifo_full;
  assign last_m = xfer & last;
  assign data_m = xfer ? data : '0;
endmodule

module fifo_wr_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_BURST  = 8,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          wr_clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH+ID_W:0]      fifo_wdata,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy
);
  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] LAST_CNT = 8'(MAX_BURST - 1);

  state_t                              state, state_nxt;
  logic [ID_W-1:0]                     rr_ptr, rr_ptr_nxt, grant_nxt, pick_id, wrap_id;
  logic [7:0]                          beat_cnt, beat_cnt_nxt;
  logic                                pick_vld, xfer, last_sel;
  logic [NUM_REQ-1:0]                  lane_last;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  lane_data;
  logic [DATA_WIDTH-1:0]               data_sel;

  // Explicit wrap so non-power-of-2 NUM_REQ never yields an out-of-range ID.
  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  assign busy = (state == GRANT);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    fifo_wr_arbiter_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .gnt       (busy && (grant_id == ID_W'(i))),
      .valid     (req_valid[i]),
      .last      (req_last[i]),
      .data      (req_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .fifo_full (fifo_full),
      .xfer      (req_ready[i]),
      .last_m    (lane_last[i]),
      .data_m    (lane_data[i])
    );
  end

  // Only the granted lane can be non-zero, so OR-reduction is the mux.
  always_comb begin
    xfer     = |req_ready;
    last_sel = |lane_last;
    data_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) data_sel = data_sel | lane_data[i];
  end

  assign fifo_wr_en = xfer;
  assign fifo_wdata = xfer ? {grant_id, last_sel, data_sel} : '0;

  // Scan from the far end so the requester closest to rr_ptr wins last.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[rr_idx(rr_ptr, k)]) begin
        pick_vld = 1'b1;
        pick_id  = rr_idx(rr_ptr, k);
      end
    end
  end

  assign wrap_id = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant_id;
    rr_ptr_nxt   = rr_ptr;
    beat_cnt_nxt = beat_cnt;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt    = GRANT;
          grant_nxt    = pick_id;
          beat_cnt_nxt = '0;
        end
      end
      GRANT: begin
        if (xfer) begin
          beat_cnt_nxt = beat_cnt + 8'd1;
          if (last_sel || beat_cnt == LAST_CNT) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = wrap_id;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant_id <= grant_nxt;
      rr_ptr   <= rr_ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the team's async FIFO between NUM_REQ requesters in the wr_clk domain.
- Each requester has a valid/ready handshake with burst locking: a grant is held until the requester's last beat or MAX_BURST beats.
- Each accepted beat is tagged with the requester ID and last flag, then driven onto the FIFO write port.
- FIFO backpressure comes from its full flag.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, payload width per requester.
- MAX_BURST, 8, maximum beats per grant (1..255).
- ID_W, derived = clog2(NUM_REQ), not overridable; 2 for the defaults.

Ports:
- wr_clk  in  1  FIFO write-domain clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_last  in  NUM_REQ  per-requester end-of-burst marker, qualified by valid.
- req_data  in  NUM_REQ*DATA_WIDTH  requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  per-requester beat accepted this cycle.
- fifo_full  in  1  FIFO full flag.
- fifo_wr_en  out  1  FIFO write enable.
- fifo_wdata  out  DATA_WIDTH+ID_W+1  {grant_id, last, data}.
- grant_id  out  ID_W  current granted requester.
- busy  out  1  high in GRANT state.

Behaviour:
- States are IDLE and GRANT. Registers: state, grant_id, rr_ptr (ID_W), beat_cnt (8 bits).
- Reset (async): state=IDLE, grant_id=0, rr_ptr=0, beat_cnt=0.
  - Consequently fifo_wr_en=0, req_ready=0, busy=0, fifo_wdata=0.
- IDLE:
  - If any req_valid is set, pick the first set bit searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Register it into grant_id, clear beat_cnt and go to GRANT.
  - Arbitration latency is 1 cycle; no beat transfers in IDLE.
- GRANT, beat transfer:
  - xfer = req_valid[grant_id] & ~fifo_full, combinational.
  - fifo_wr_en = xfer.
  - req_ready[grant_id] = xfer; all other req_ready bits = 0.
  - fifo_wdata = {grant_id, req_last[grant_id], req_data slice of grant_id}. It is 0 whenever xfer=0.
- GRANT, beat accounting:
  - On xfer, beat_cnt increments.
  - Release when xfer and (req_last[grant_id] or beat_cnt==MAX_BURST-1).
  - On release: state goes to IDLE and rr_ptr = (grant_id+1) mod NUM_REQ.
- Stalls:
  - fifo_full=1 or valid low holds GRANT with no transfer and no count change. There is no timeout.
  - A requester must not drop valid mid-burst; if it does, the grant is simply held.
- Re-arbitration: one IDLE bubble cycle between consecutive grants is mandatory, including when the same requester re-wins.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,...,NUM_REQ-1,0.
- MAX_BURST=1: every accepted beat releases the grant.
- Request changes: req_valid changes on other requesters during GRANT are ignored until IDLE.
- fifo_full is sampled as-is; the block never writes while fifo_full=1.
- Reset mid-burst: the grant is abandoned immediately, with no further writes; rr_ptr returns to 0.
- Non-power-of-2 NUM_REQ: the modulo wrap is explicit and ID values >= NUM_REQ never appear.

Test Plan:
- Reset with all valid high, then release rst → fifo_wr_en=0 during reset. Cycle 1 after release is IDLE (grant to req0 latched); beats from req0 start at cycle 2 with fifo_wdata ID=0.
- Single requester: req2 sends 3 beats, data 0xA1,0xA2,0xA3, last on the 3rd → 3 consecutive FIFO writes, fifo_wdata={2,0,A1},{2,0,A2},{2,1,A3}; busy drops the next cycle; rr_ptr=3.
- All 4 requesters valid, each sending 2-beat bursts → grant order 0,1,2,3,0. Exactly 1 idle cycle between bursts; no beat interleaving.
- Req1 streams 20 beats with no last, MAX_BURST=8 → released after beat 8. Req1 regains the grant only after the other pending requesters are served; the total of 20 beats arrives in order.
- fifo_full asserted for 5 cycles mid-burst → zero writes and req_ready=0 during those cycles; beat_cnt is unchanged; the burst resumes with no lost or duplicated data.
- rst pulsed during beat 3 of a 6-beat burst → fifo_wr_en low immediately. After release, arbitration restarts from req0 and no stale beats are written.
